fixed_to_posit: RTL and testbench

Sequential converter from signed two's-complement fixed-point to posit⟨N,ES⟩, the encode-direction counterpart of the posit decode/arithmetic datapath. It normalises the input iteratively, one bit per cycle, then packs regime, exponent and fraction with round-to-nearest-even. It sits in front of the posit add/mult units, turning integrator and DDA fixed-point values into posit operands, with valid/ready handshakes on both sides.

---
 rtl/posit_pkg.sv | 30 +++
 rtl/posit_pack.sv | 61 ++++++
 rtl/fixed_to_posit.sv | 105 ++++++++++
 tb/tb_fixed_to_posit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: default format, converter state encoding and
// saturation constants used by the encode and arithmetic datapaths.
package posit_pkg;

    localparam int POSIT_N  = 16;
    localparam int POSIT_ES = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } conv_state_t;

    localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
    localparam logic [POSIT_N-1:0] MINPOS = POSIT_N'(1);

    // Largest |scale| representable before the regime runs out of bits.
    localparam int MAX_SCALE = (POSIT_N - 2) << POSIT_ES;

endpackage

// File: rtl/posit_pack.sv
// Combinational posit packer: (sign, scale, fraction) -> rounded, saturated posit.
// Shared with the arithmetic units' final stage.
module posit_pack
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int SW = 6,
    parameter int FW = 15
) (
    input  logic                 sign,
    input  logic signed [SW-1:0] scale,
    input  logic [FW-1:0]        fraction,
    output logic [N-1:0]         posit
);

    localparam int LW = 2 + ES + FW + N;
    localparam int SAT_SCALE = (N - 2) << ES;
    localparam logic [N-1:0] MAX_MAG = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_MAG = N'(1);

    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    int                   scale_i;
    int                   shift_i;
    logic signed [LW-1:0] body;
    logic signed [LW-1:0] shifted;
    logic [N-2:0]         kept;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [N-1:0]         rounded;
    logic [N-1:0]         mag_p;

    // The regime is formed by arithmetic-shifting a seed "10" (k >= 0, fills
    // ones) or "01" (k < 0, fills zeros); the padding keeps every dropped bit
    // available for the sticky term.
    always_comb begin
        k        = scale >>> ES;
        e        = scale[ES-1:0];
        scale_i  = int'(scale);
        shift_i  = (k >= 0) ? int'(k) : (-int'(k) - 1);
        if (shift_i > N) shift_i = N;
        body     = {(k < 0) ? 2'b01 : 2'b10, e, fraction, {N{1'b0}}};
        shifted  = body >>> shift_i;
        kept     = shifted[LW-1 -: N-1];
        guard    = shifted[LW-N];
        sticky   = |shifted[LW-N-1:0];
        round_up = guard & (sticky | kept[0]);
        rounded  = {1'b0, kept} + N'(round_up);

        if (scale_i > SAT_SCALE)       mag_p = MAX_MAG;
        else if (scale_i < -SAT_SCALE) mag_p = MIN_MAG;
        else if (rounded[N-1])         mag_p = MAX_MAG;
        else if (rounded == '0)        mag_p = MIN_MAG;
        else                           mag_p = rounded;

        posit = sign ? (~mag_p + N'(1)) : mag_p;
    end

endmodule

// File: rtl/fixed_to_posit.sv
// Sequential signed fixed-point to posit converter: one-bit-per-cycle
// normalisation followed by a single pack/round step, valid/ready on both sides.
module fixed_to_posit
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int W  = 16,
    parameter int F  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_fix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_posit,
    output logic         out_zero
);

    localparam int LZW = clog2(W);
    localparam int SW  = clog2(W) + 2;

    conv_state_t          state;
    conv_state_t          next_state;
    logic [W-1:0]         mag;
    logic [LZW-1:0]       lz;
    logic                 sign;
    logic signed [SW-1:0] scale;
    logic [N-1:0]         pack_posit;

    assign scale     = SW'(W - 1 - F) - SW'(lz);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    posit_pack #(
        .N  (N),
        .ES (ES),
        .SW (SW),
        .FW (W - 1)
    ) u_pack (
        .sign     (sign),
        .scale    (scale),
        .fraction (mag[W-2:0]),
        .posit    (pack_posit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A zero input also passes through PACK so its result lands one edge
    // after acceptance; NORM would never terminate on an all-zero magnitude.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = (in_fix == '0) ? PACK : NORM;
            NORM: if (mag[W-1]) next_state = PACK;
            PACK: next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            lz        <= '0;
            sign      <= 1'b0;
            out_posit <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign      <= in_fix[W-1];
                        mag       <= in_fix[W-1] ? (~in_fix + W'(1)) : in_fix;
                        lz        <= '0;
                        out_posit <= '0;
                        out_zero  <= 1'b0;
                    end
                end
                NORM: begin
                    if (!mag[W-1]) begin
                        mag <= mag << 1;
                        lz  <= lz + LZW'(1);
                    end
                end
                PACK: begin
                    if (mag == '0) begin
                        out_posit <= '0;
                        out_zero  <= 1'b1;
                    end else begin
                        out_posit <= pack_posit;
                        out_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_posit.sv
// Randomised self-checking bench for fixed_to_posit; the reference picks the
// nearest posit by value search over decoded posits.
module tb_fixed_to_posit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_fix;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;
    logic        out_zero;

    int tests_run  = 0;
    int fail_count = 0;

    fixed_to_posit #(.N(16), .ES(3), .W(16), .F(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fix    (in_fix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic real pow2(input int s);
        real r;
        r = 1.0;
        if (s >= 0) for (int i = 0; i < s; i++) r = r * 2.0;
        else        for (int i = 0; i < -s; i++) r = r * 0.5;
        return r;
    endfunction

    // Exact value of a positive posit<16,3> given its 15 magnitude bits.
    function automatic real posit_val(input int p);
        int  i, run, k, e, fl, f;
        logic first;
        first = p[14];
        i = 14;
        run = 0;
        while (i >= 0 && p[i] == first) begin
            run++;
            i--;
        end
        k = first ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < 3; j++) begin
            e = e * 2;
            if (i >= 0) e = e + int'(p[i]);
            i--;
        end
        fl = (i >= 0) ? i + 1 : 0;
        f  = p & ((1 << fl) - 1);
        return pow2(k * 8 + e) * (1.0 + real'(f) * pow2(-fl));
    endfunction

    task automatic refModel(input logic [15:0] v, output logic [15:0] p, output logic z, output int lat);
        int  sv, mag, msb, lo, hi, mid, best, pm;
        real x, a, b, half;
        sv  = int'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        if (mag == 0) begin
            p = 16'h0000;
            z = 1'b1;
            lat = 1;
            return;
        end
        msb = 0;
        for (int i = 0; i < 16; i++) if (mag >= (1 << i)) msb = i;
        lat = (15 - msb) + 2;
        z = 1'b0;
        x = real'(mag) / 256.0;
        lo = 1;
        hi = 32767;
        best = 0;
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            if (posit_val(mid) <= x) begin
                best = mid;
                lo = mid + 1;
            end else begin
                hi = mid - 1;
            end
        end
        if (best == 0) pm = 1;
        else if (best == 32767) pm = 32767;
        else begin
            a = posit_val(best);
            b = posit_val(best + 1);
            half = (a + b) / 2.0;
            if (x > half)      pm = best + 1;
            else if (x < half) pm = best;
            else               pm = (best % 2 == 1) ? best + 1 : best;
        end
        p = (sv < 0) ? 16'(-pm) : 16'(pm);
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int hold_cycles, output logic [15:0] observed);
        logic [15:0] exp_p;
        logic        exp_z;
        int          exp_lat;
        int          edges;
        refModel(value, exp_p, exp_z, exp_lat);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_fix   = value;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fix   = 16'($urandom);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("latency", 32'(edges), 32'(exp_lat));
        checkOutput("posit", 32'(out_posit), 32'(exp_p));
        checkOutput("zero", 32'(out_zero), 32'(exp_z));
        observed = out_posit;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;
            in_fix   = 16'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold_posit", 32'(out_posit), 32'(exp_p));
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("hs_valid_low", 32'(out_valid), 32'd0);
        checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [15:0] dir_in  [8] = '{16'h0100, 16'hFF00, 16'h8000, 16'h0000,
                                 16'h0001, 16'h7FFF, 16'h4008, 16'h4018};
    logic [15:0] dir_exp [8] = '{16'h4000, 16'hC000, 16'hA400, 16'h0000,
                                 16'h2000, 16'h5C00, 16'h5800, 16'h5802};

    initial begin
        logic [15:0] obs;
        logic [15:0] v;
        logic        seen;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_fix    = '0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_posit", 32'(out_posit), 32'd0);
        checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(dir_in[i], 0, obs);
            checkOutput("directed", 32'(obs), 32'(dir_exp[i]));
        end

        applyStimulus(16'h0280, 5, obs);

        // Abort a long conversion mid-normalisation.
        @(negedge clk);
        in_fix   = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("norm_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_posit", 32'(out_posit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("midrst_no_emit", 32'(seen), 32'd0);
        applyStimulus(16'hFD80, 0, obs);

        for (int t = 0; t < 150; t++) begin
            v = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) v = -v;
            applyStimulus(v, $urandom_range(0, 2), obs);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
